// File: rtl/head_merge_pkg.sv
// head_merge_pkg: FSM state and geometry helpers shared by the head merge buffer.
package head_merge_pkg;
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;
    function automatic int chunk_num(input int head_num, input int heads_per_chunk);
        return head_num / heads_per_chunk;
    endfunction
    function automatic int chunk_bits(input int data_width, input int seq_len,
                                      input int heads_per_chunk, input int head_dim);
        return data_width * seq_len * heads_per_chunk * head_dim;
    endfunction
    // Output element index of chunk element (s,h,d) from chunk k, for either layout.
    function automatic int out_elem_index(input int s, input int h, input int d, input int k,
                                          input int seq_len, input int heads_per_chunk,
                                          input int head_dim, input int head_num,
                                          input bit interleave);
        return interleave ? (s * head_num + k * heads_per_chunk + h) * head_dim + d
                          : ((k * seq_len + s) * heads_per_chunk + h) * head_dim + d;
    endfunction
endpackage

// File: rtl/head_merge_scatter.sv
// head_merge_scatter: slot decode and placement of one chunk into the merged storage;
// HEAD_MERGE_INTERLEAVE_EN selects the row-interleaved layout instead of concatenation.
module head_merge_scatter import head_merge_pkg::*; #(
    parameter int DATA_WIDTH      = 8,
    parameter int SEQ_LEN         = 128,
    parameter int HEADS_PER_CHUNK = 4,
    parameter int HEAD_DIM        = 64,
    parameter int HEAD_NUM        = 12,
    parameter int IDX_WIDTH       = 4,
    localparam int CHUNK_NUM  = chunk_num(HEAD_NUM, HEADS_PER_CHUNK),
    localparam int CHUNK_BITS = chunk_bits(DATA_WIDTH, SEQ_LEN, HEADS_PER_CHUNK, HEAD_DIM),
    localparam int OUT_BITS   = CHUNK_BITS * CHUNK_NUM
) (
    input  logic                  wr,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [CHUNK_BITS-1:0] chunk,
    input  logic [OUT_BITS-1:0]   store_q,
    output logic [OUT_BITS-1:0]   store_d,
    output logic [CHUNK_NUM-1:0]  slot_we
);
    localparam int EPC = SEQ_LEN * HEADS_PER_CHUNK * HEAD_DIM;

    for (genvar k = 0; k < CHUNK_NUM; k++) begin : g_slot
        assign slot_we[k] = wr && idx == IDX_WIDTH'(k);
`ifdef HEAD_MERGE_INTERLEAVE_EN
        for (genvar e = 0; e < EPC; e++) begin : g_elem
            localparam int OFS = out_elem_index(e / (HEADS_PER_CHUNK * HEAD_DIM),
                                                (e / HEAD_DIM) % HEADS_PER_CHUNK, e % HEAD_DIM, k,
                                                SEQ_LEN, HEADS_PER_CHUNK, HEAD_DIM, HEAD_NUM, 1'b1);
            assign store_d[OFS*DATA_WIDTH +: DATA_WIDTH] = slot_we[k] ? chunk[e*DATA_WIDTH +: DATA_WIDTH]
                                                                      : store_q[OFS*DATA_WIDTH +: DATA_WIDTH];
        end
`else
        assign store_d[k*CHUNK_BITS +: CHUNK_BITS] = slot_we[k] ? chunk : store_q[k*CHUNK_BITS +: CHUNK_BITS];
`endif
    end
endmodule

// File: rtl/head_merge_buffer.sv
// head_merge_buffer: collects out-of-order head-group chunks into one merged matrix and holds it
// until downstream accepts; HEAD_MERGE_INTERLEAVE_EN selects row-interleaved output layout.
module head_merge_buffer import head_merge_pkg::*; #(
    parameter int DATA_WIDTH      = 8,
    parameter int SEQ_LEN         = 128,
    parameter int HEADS_PER_CHUNK = 4,
    parameter int HEAD_DIM        = 64,
    parameter int HEAD_NUM        = 12,
    parameter int IDX_WIDTH       = 4,
    localparam int CHUNK_NUM  = chunk_num(HEAD_NUM, HEADS_PER_CHUNK),
    localparam int CHUNK_BITS = chunk_bits(DATA_WIDTH, SEQ_LEN, HEADS_PER_CHUNK, HEAD_DIM),
    localparam int OUT_BITS   = CHUNK_BITS * CHUNK_NUM
) (
    input  logic                  clk_p,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_WIDTH-1:0]  in_idx,
    input  logic [CHUNK_BITS-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_BITS-1:0]   out_data,
    output logic [CHUNK_NUM-1:0]  fill_mask,
    output logic                  err_idx,
    output logic                  err_dup
);
    if (HEAD_NUM % HEADS_PER_CHUNK != 0 || (1 << IDX_WIDTH) < CHUNK_NUM) begin : g_bad_cfg
        $error("head_merge_buffer: HEAD_NUM must be a multiple of HEADS_PER_CHUNK and IDX_WIDTH must cover CHUNK_NUM");
    end

    localparam logic [IDX_WIDTH:0] CN = (IDX_WIDTH + 1)'(CHUNK_NUM);

    state_t                state_q, state_d;
    logic [OUT_BITS-1:0]   store_q, store_d;
    logic [CHUNK_NUM-1:0]  mask_q, slot_we;
    logic                  accept, in_range, wr, dup, done;

    assign accept   = in_valid && state_q == FILL;
    assign in_range = {1'b0, in_idx} < CN;
    assign wr       = accept && in_range;
    assign dup      = |(slot_we & mask_q);
    assign done     = wr && &(mask_q | slot_we);

    head_merge_scatter #(
        .DATA_WIDTH(DATA_WIDTH), .SEQ_LEN(SEQ_LEN), .HEADS_PER_CHUNK(HEADS_PER_CHUNK),
        .HEAD_DIM(HEAD_DIM), .HEAD_NUM(HEAD_NUM), .IDX_WIDTH(IDX_WIDTH)
    ) u_scatter (
        .wr(wr), .idx(in_idx), .chunk(in_data), .store_q(store_q), .store_d(store_d), .slot_we(slot_we)
    );

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == FILL) state_d = done ? HOLD : FILL;
        else                 state_d = out_ready ? FILL : HOLD;
    end

    always_comb begin
        in_ready  = state_q == FILL;
        out_valid = state_q == HOLD;
    end

    // Mask clears on the output handshake; storage only moves on in-range accepts.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            store_q <= '0;
            err_idx <= 1'b0;
            err_dup <= 1'b0;
        end else begin
            err_idx <= accept && !in_range;
            err_dup <= wr && dup;
            if (state_q == HOLD && out_ready) mask_q <= '0;
            else if (wr)                      mask_q <= mask_q | slot_we;
            if (wr) store_q <= store_d;
        end
    end

    assign out_data  = store_q;
    assign fill_mask = mask_q;
endmodule

// File: tb/tb_head_merge_buffer.sv
// tb_head_merge_buffer: vector table, corner sequences and random traffic against a slot-level model.
module tb_head_merge_buffer;
    localparam int DW = 8, SEQ = 2, HPC = 2, HD = 2, HN = 6, IW = 4;
    localparam int CN = HN / HPC, CB = DW * SEQ * HPC * HD, OB = CB * CN;

    logic          clk_p = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, err_idx, err_dup;
    logic [IW-1:0] in_idx = '0;
    logic [CB-1:0] in_data = '0;
    logic [OB-1:0] out_data;
    logic [CN-1:0] fill_mask;

    int checks = 0, errors = 0;

    bit            m_hold, m_eidx, m_edup;
    bit [CN-1:0]   m_mask;
    logic [CB-1:0] m_slot[CN];

    typedef struct {
        bit v; bit [IW-1:0] idx; logic [CB-1:0] data; bit ordy;
        bit [CN-1:0] m; bit ov; bit ei; bit ed;
    } vec_t;
    vec_t tab[$];

    head_merge_buffer #(
        .DATA_WIDTH(DW), .SEQ_LEN(SEQ), .HEADS_PER_CHUNK(HPC), .HEAD_DIM(HD), .HEAD_NUM(HN), .IDX_WIDTH(IW)
    ) dut (
        .clk_p(clk_p), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fill_mask(fill_mask), .err_idx(err_idx), .err_dup(err_dup)
    );

    always #5 clk_p = ~clk_p;

    function automatic logic [CB-1:0] pat(input int k);
        logic [CB-1:0] r;
        for (int e = 0; e < CB / DW; e++) r[e*DW +: DW] = 8'(8'h10 * k + e);
        return r;
    endfunction

    // Merged matrix built element by element from the stored chunks.
    function automatic logic [OB-1:0] exp_out();
        logic [OB-1:0] r = '0;
        int e, o;
        for (int k = 0; k < CN; k++)
            for (int s = 0; s < SEQ; s++)
                for (int h = 0; h < HPC; h++)
                    for (int d = 0; d < HD; d++) begin
                        e = (s * HPC + h) * HD + d;
`ifdef HEAD_MERGE_INTERLEAVE_EN
                        o = (s * HN + k * HPC + h) * HD + d;
`else
                        o = k * (CB / DW) + e;
`endif
                        r[o*DW +: DW] = m_slot[k][e*DW +: DW];
                    end
        return r;
    endfunction

    function automatic void model_reset();
        m_hold = 0; m_mask = '0; m_eidx = 0; m_edup = 0;
        for (int k = 0; k < CN; k++) m_slot[k] = '0;
    endfunction

    function automatic void model_step(input bit v, input int idx, input logic [CB-1:0] data, input bit ordy);
        m_eidx = 0; m_edup = 0;
        if (!m_hold) begin
            if (v && idx >= CN) m_eidx = 1;
            else if (v) begin
                m_edup = m_mask[idx];
                m_mask[idx] = 1'b1;
                m_slot[idx] = data;
                m_hold = &m_mask;
            end
        end else if (ordy) begin
            m_hold = 0; m_mask = '0;
        end
    endfunction

    task automatic chk(input string name, input logic [OB-1:0] act, input logic [OB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("out_valid", OB'(out_valid), OB'(m_hold));
        chk("in_ready", OB'(in_ready), OB'(!m_hold));
        chk("fill_mask", OB'(fill_mask), OB'(m_mask));
        chk("err_idx", OB'(err_idx), OB'(m_eidx));
        chk("err_dup", OB'(err_dup), OB'(m_edup));
        chk("out_data", out_data, exp_out());
    endtask

    task automatic apply(input bit v, input int idx, input logic [CB-1:0] data, input bit ordy);
        in_valid = v; in_idx = IW'(idx); in_data = data; out_ready = ordy;
        @(posedge clk_p);
        #1;
        model_step(v, idx, data, ordy);
        check_model();
    endtask

    initial begin
        model_reset();
        #3;
        chk("reset_out_valid", OB'(out_valid), '0);
        chk("reset_fill_mask", OB'(fill_mask), '0);
        chk("reset_out_data", out_data, '0);
        chk("reset_in_ready", OB'(in_ready), OB'(1));
        @(posedge clk_p);
        #1 rst_n = 1'b1;

        // in order, HOLD ignoring input, release; out of order; out of range; duplicate
        tab.push_back('{1, 0, pat(0), 0, 3'b001, 0, 0, 0});
        tab.push_back('{1, 1, pat(1), 0, 3'b011, 0, 0, 0});
        tab.push_back('{1, 2, pat(2), 0, 3'b111, 1, 0, 0});
        tab.push_back('{0, 0, '0,     0, 3'b111, 1, 0, 0});
        tab.push_back('{1, 0, '1,     0, 3'b111, 1, 0, 0});
        tab.push_back('{0, 0, '0,     1, 3'b000, 0, 0, 0});
        tab.push_back('{1, 2, pat(2), 0, 3'b100, 0, 0, 0});
        tab.push_back('{1, 0, pat(0), 0, 3'b101, 0, 0, 0});
        tab.push_back('{1, 1, pat(1), 0, 3'b111, 1, 0, 0});
        tab.push_back('{0, 0, '0,     1, 3'b000, 0, 0, 0});
        tab.push_back('{1, 3, pat(0), 0, 3'b000, 0, 1, 0});
        tab.push_back('{1, 15, pat(0), 0, 3'b000, 0, 1, 0});
        tab.push_back('{0, 0, '0,     0, 3'b000, 0, 0, 0});
        tab.push_back('{1, 1, pat(1), 0, 3'b010, 0, 0, 0});
        tab.push_back('{1, 1, {8{8'hAA}}, 0, 3'b010, 0, 0, 1});
        tab.push_back('{1, 0, pat(0), 0, 3'b011, 0, 0, 0});
        tab.push_back('{1, 2, pat(2), 0, 3'b111, 1, 0, 0});
        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i].v, int'(tab[i].idx), tab[i].data, tab[i].ordy);
            chk($sformatf("tab%0d_mask", i), OB'(fill_mask), OB'(tab[i].m));
            chk($sformatf("tab%0d_valid", i), OB'(out_valid), OB'(tab[i].ov));
            chk($sformatf("tab%0d_err_idx", i), OB'(err_idx), OB'(tab[i].ei));
            chk($sformatf("tab%0d_err_dup", i), OB'(err_dup), OB'(tab[i].ed));
        end
        chk("dup_slot1_aa", OB'(m_slot[1]), OB'({8{8'hAA}}));

        // Backpressure: held matrix stays frozen even with new input offered.
        for (int i = 0; i < 10; i++) apply(i[0], 0, pat(5), 0);
        apply(0, 0, '0, 1);
        apply(1, 2, {$urandom, $urandom}, 0);
        apply(1, 0, {$urandom, $urandom}, 0);
        apply(1, 1, {$urandom, $urandom}, 0);
        chk("refill_valid", OB'(out_valid), OB'(1));
        apply(0, 0, '0, 1);

        // Asynchronous reset in the middle of a fill.
        apply(1, 0, pat(0), 0);
        apply(1, 1, pat(1), 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_out_valid", OB'(out_valid), '0);
        chk("midrst_fill_mask", OB'(fill_mask), '0);
        chk("midrst_out_data", out_data, '0);
        #1 rst_n = 1'b1;
        apply(1, 2, pat(2), 0);
        chk("midrst_no_valid", OB'(out_valid), '0);
        apply(0, 0, '0, 0);

        for (int i = 0; i < 400; i++)
            apply($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)),
                  {$urandom, $urandom}, $urandom_range(0, 2) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/head_merge_buffer.md
Name: head_merge_buffer

Overview:
Multi-head attention merge stage. Collects HEAD_NUM/HEADS_PER_CHUNK head-group chunks, which may arrive in any order and are tagged by chunk index. It assembles them into one merged [SEQ_LEN x HEAD_NUM*HEAD_DIM] matrix and holds that matrix until downstream accepts it. It sits between the per-head attention output and the output projection.

Parameters:
DATA_WIDTH, 8, element width in bits
SEQ_LEN, 128, rows (tokens)
HEADS_PER_CHUNK, 4, heads carried per input chunk
HEAD_DIM, 64, columns per head
HEAD_NUM, 12, total heads; must be a multiple of HEADS_PER_CHUNK (elaboration error otherwise)
IDX_WIDTH, 4, width of chunk index port; must satisfy 2^IDX_WIDTH >= CHUNK_NUM
Derived: CHUNK_NUM = HEAD_NUM/HEADS_PER_CHUNK; CHUNK_BITS = DATA_WIDTH*SEQ_LEN*HEADS_PER_CHUNK*HEAD_DIM; OUT_BITS = CHUNK_BITS*CHUNK_NUM

Ports:
clk_p  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  chunk present
in_ready  out  1  block accepts a chunk this cycle
in_idx  in  IDX_WIDTH  chunk index, unsigned
in_data  in  CHUNK_BITS  chunk, element (s,h,d) at flat index (s*HEADS_PER_CHUNK+h)*HEAD_DIM+d
out_valid  out  1  merged matrix complete
out_ready  in  1  downstream accepts
out_data  out  OUT_BITS  merged matrix
fill_mask  out  CHUNK_NUM  bit k set = chunk k stored
err_idx  out  1  one-cycle pulse: out-of-range index dropped
err_dup  out  1  one-cycle pulse: duplicate chunk overwrote stored data

Behaviour:
- Reset (async, any state): FSM = FILL; fill_mask = 0; storage = 0; out_valid = 0; err_idx = 0; err_dup = 0. Reset mid-fill discards all partial chunks.
- States: FILL and HOLD.
- FILL:
  - in_ready = 1; accept when in_valid.
  - in_idx >= CHUNK_NUM: no write, mask unchanged, err_idx = 1 next cycle.
  - Valid in_idx: write chunk into its slot, set mask bit.
  - Mask bit already set: data overwritten, err_dup = 1 next cycle, no extra progress toward completion.
  - If the accept completes the mask (all ones), go to HOLD next edge.
- HOLD:
  - out_valid = 1, in_ready = 0; storage frozen.
  - On out_ready: clear fill_mask, return to FILL; out_valid = 0 next cycle; in_ready = 1 next cycle.
- Latency: out_valid rises on the first edge after the final chunk is accepted. A new fill can begin the cycle after the out handshake (1 bubble). Minimum period is CHUNK_NUM+1 cycles.
- out_data is registered; it changes only on accepts in FILL and is stable throughout HOLD.
- CHUNK_NUM = 1: every valid accept goes directly to HOLD.
- Error pulses are mutually exclusive and last exactly one cycle.

Optional Feature:
Macro HEAD_MERGE_INTERLEAVE_EN.
- Defined: row-interleaved placement, giving true [SEQ][HEAD][DIM] layout. Input element (s,h,d) of chunk k lands at output flat index (s*HEAD_NUM + k*HEADS_PER_CHUNK + h)*HEAD_DIM + d, bits [idx*DATA_WIDTH +: DATA_WIDTH].
- Undefined: plain concatenation. Chunk k occupies out_data[k*CHUNK_BITS +: CHUNK_BITS] unchanged.
- Handshake, FSM, mask and errors are identical in both builds.

Decomposition:
- Package head_merge_pkg: FSM state enum (FILL, HOLD); functions chunk_num(), chunk_bits(), and out_elem_index(s,h,d,k) for both layouts.
- Sub-module head_merge_scatter: per-slot write enables and the placement/muxing of one chunk into the storage vector, layout selected by the macro. Top level keeps FSM, mask, errors and handshake.

Test Plan (DATA_WIDTH=8, SEQ_LEN=2, HEADS_PER_CHUNK=2, HEAD_DIM=2, HEAD_NUM=6, so CHUNK_NUM=3; chunk k elements = 8'h10*k + element index):
1. In-order fill. Send idx 0,1,2 back-to-back with out_ready=0 -> out_valid=1 one cycle after idx 2 is accepted; in_ready=0; out_data matches the model for the active layout (concat: bytes 0x00..0x07, 0x10..0x17, 0x20..0x27).
2. Out-of-order fill. Send idx 2,0,1 -> same out_data as scenario 1; fill_mask steps 100, 101, 111.
3. Duplicate. Send idx 1, then idx 1 with all bytes 0xAA, then 0, 2 -> err_dup pulses once; out_valid only after idx 2; slot 1 holds 0xAA.
4. Out of range. Send idx 3 and idx 15 -> err_idx pulses twice; fill_mask stays 000; out_valid stays 0.
5. Backpressure and reuse. Hold out_ready=0 for 10 cycles in HOLD -> out_data stable and in_ready=0. Raise out_ready -> out_valid=0 and in_ready=1 next cycle; a second fill produces the new data.
6. Reset mid-fill. Accept idx 0,1, assert rst_n=0 asynchronously -> outputs zero immediately; after release, a fill of idx 2 alone does not assert out_valid.
